// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and frame geometry.
// The oversample default is also used by the baud generator.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input pin; 2 CLK latency, no backpressure.
// Both flops reset to RST_VAL so an idle-high line never looks active out of reset.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; byte valid 1 CLK after the stop-bit sample.
// Output is a single holding register: a byte arriving while it is full and not draining is dropped (overrun).
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int CNT_W      = 4
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [2:0]                bit_idx, bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
  logic                      deliver;
  logic                      stop_err;
  logic                      take;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .async_in (RX),
    .sync_out (rx_s)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Every compare hit clears cnt, so it only ever counts up to CNT_END.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    deliver     = 1'b0;
    stop_err    = 1'b0;
    if (sample_tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt_nxt   = '0;
            state_nxt = S_START;
          end
        end
        S_START: begin
          if (cnt == CNT_MID) begin
            cnt_nxt = '0;
            if (rx_s) begin
              state_nxt = S_IDLE;
            end else begin
              bit_idx_nxt = '0;
              state_nxt   = S_DATA;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt == CNT_END) begin
            shreg_nxt   = {rx_s, shreg[UART_DATA_BITS-1:1]};
            cnt_nxt     = '0;
            bit_idx_nxt = bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state_nxt = S_STOP;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt == CNT_END) begin
            cnt_nxt = '0;
            if (rx_s) begin
              deliver   = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              stop_err  = 1'b1;
              state_nxt = S_WAIT_HIGH;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The register can take a new byte if empty or draining in this same cycle.
  assign take = !valid_out || ready_in;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_err;
      overrun   <= deliver && !take;
      if (deliver && take) begin
        data_out  <= shreg;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at 4 CLK per sample_tick, scoreboard of delivered bytes.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       sample_tick;
  logic       RX;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int vld_cycles = 0;
  int ferr_cycles = 0;
  int ovr_cycles = 0;
  int xfers = 0;
  int ph = 0;
  int v0, f0, o0, x0;
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(16), .CNT_W(4)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .RX          (RX),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      ph = (ph + 1) % 4;
      sample_tick = (ph == 3);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted transfer pops one expected byte.
  always @(negedge CLK) begin
    if (rst_n === 1'b1) begin
      if (valid_out) vld_cycles++;
      if (frame_err) ferr_cycles++;
      if (overrun) ovr_cycles++;
      if (valid_out && ready_in) begin
        xfers++;
        check("xfer_q_empty", 32'(exp_q.size() == 0), 32'd0);
        if (exp_q.size() != 0) check("xfer_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    do begin
      @(posedge CLK);
      #2;
    end while (sample_tick !== 1'b1);
  endtask

  task automatic hold(input logic v, input int n);
    RX = v;
    repeat (n) wait_tick();
  endtask

  // Caller is positioned in a tick cycle; frame occupies 160 ticks from here.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_t);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int t = 0; t < 160; t++) begin
      RX = f[t/16];
      if (t == rdy_t) begin
        ready_in = 1'b1;
        @(posedge CLK);
        #2;
        ready_in = 1'b0;
      end
      wait_tick();
    end
  endtask

  task automatic snap();
    v0 = vld_cycles; f0 = ferr_cycles; o0 = ovr_cycles; x0 = xfers;
  endtask

  initial begin
    RX = 1'b1;
    ready_in = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_tick();
    hold(1'b1, 16);

    // Single byte, consumer always ready
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    hold(1'b1, 16);
    check("a5_xfers", 32'(xfers - x0), 32'd1);
    check("a5_vld_cycles", 32'(vld_cycles - v0), 32'd1);
    check("a5_ferr", 32'(ferr_cycles - f0), 32'd0);
    check("a5_ovr", 32'(ovr_cycles - o0), 32'd0);

    // Start-bit glitch
    snap();
    hold(1'b0, 2);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    hold(1'b0, 2);
    hold(1'b1, 8);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    hold(1'b1, 16);
    check("glitch_vld", 32'(vld_cycles - v0), 32'd0);
    check("glitch_ferr", 32'(ferr_cycles - f0), 32'd0);

    // Stop bit low, line stuck low, then recovery
    snap();
    send_frame(8'h3C, 1'b0, -1);
    hold(1'b0, 24);
    check("ferr_busy_low_line", 32'(busy), 32'd1);
    hold(1'b0, 24);
    check("ferr_pulses", 32'(ferr_cycles - f0), 32'd1);
    check("ferr_no_vld", 32'(vld_cycles - v0), 32'd0);
    hold(1'b1, 4);
    check("ferr_busy_released", 32'(busy), 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    hold(1'b1, 16);
    check("5a_xfers", 32'(xfers - x0), 32'd1);

    // Back-to-back with consumer stalled: second byte overruns
    snap();
    ready_in = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    check("ovr_valid", 32'(valid_out), 32'd1);
    check("ovr_data_held", 32'(data_out), 32'h11);
    check("ovr_pulses", 32'(ovr_cycles - o0), 32'd1);
    check("ovr_no_xfer", 32'(xfers - x0), 32'd0);
    ready_in = 1'b1;
    @(posedge CLK);
    #2;
    ready_in = 1'b0;
    check("ovr_drain_valid", 32'(valid_out), 32'd0);
    check("ovr_drain_xfer", 32'(xfers - x0), 32'd1);
    wait_tick();
    hold(1'b1, 16);

    // Consumer accepts exactly on the second delivery cycle (stop sample at tick 153)
    snap();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, 153);
    check("same_cyc_valid", 32'(valid_out), 32'd1);
    check("same_cyc_data", 32'(data_out), 32'h22);
    check("same_cyc_ovr", 32'(ovr_cycles - o0), 32'd0);
    check("same_cyc_xfer", 32'(xfers - x0), 32'd1);
    ready_in = 1'b1;
    @(posedge CLK);
    #2;
    check("same_cyc_drain", 32'(valid_out), 32'd0);
    wait_tick();
    hold(1'b1, 16);

    // Async reset mid-frame while a byte is held
    ready_in = 1'b0;
    send_frame(8'h77, 1'b1, -1);
    check("held_before_rst", 32'(data_out), 32'h77);
    hold(1'b0, 16);
    hold(1'b1, 64);
    hold(1'b1, 8);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", 32'(data_out), 32'h00);
    check("rst_mid_valid", 32'(valid_out), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ferr", 32'(frame_err), 32'd0);
    check("rst_mid_ovr", 32'(overrun), 32'd0);
    RX = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    rst_n = 1'b1;
    ready_in = 1'b1;
    wait_tick();
    hold(1'b1, 16);
    snap();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    hold(1'b1, 16);
    check("81_xfers", 32'(xfers - x0), 32'd1);
    check("81_ferr", 32'(ferr_cycles - f0), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("total_xfers", 32'(xfers), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
